// File: rtl/rng_draw.sv
// Random card-value generator for the blackjack datapath: free-running Galois LFSR,
// bounded rejection sampling into [MIN_VAL, MAX_VAL], debounced button, 2-digit 7-seg.
module rng_draw #(
  parameter int          LFSR_W       = 16,
  parameter logic [31:0] SEED         = 32'h0000_ACE1,
  parameter int          MIN_VAL      = 1,
  parameter int          MAX_VAL      = 13,
  parameter int          DEBOUNCE_CYC = 1000000,
  parameter int          MAX_TRY      = 8,
  localparam int         VAL_W        = $clog2(MAX_VAL + 1)
) (
  input  logic             CLOCK_50,
  input  logic [1:0]       KEY,
  input  logic             draw_req,
  output logic [VAL_W-1:0] rand_val,
  output logic             rand_valid,
  output logic             busy,
  output logic [7:0]       draw_count,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1
);

  localparam int RANGE = MAX_VAL - MIN_VAL + 1;
  localparam int K     = (RANGE > 1) ? $clog2(RANGE) : 1;
  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TRY_W = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;

  // Right-shifting Galois masks for maximal-length polynomials of each legal width.
  localparam logic [31:0] TAPS_ALL = (LFSR_W == 8)  ? 32'h0000_00B8 :
                                     (LFSR_W == 16) ? 32'h0000_B400 :
                                     (LFSR_W == 24) ? 32'h00E1_0000 :
                                                      32'h8020_0003;
  localparam logic [LFSR_W-1:0] TAPS   = TAPS_ALL[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] SEED_W = LFSR_W'(SEED);

  generate
    if (LFSR_W != 8 && LFSR_W != 16 && LFSR_W != 24 && LFSR_W != 32) begin : g_bad_width
      $error("rng_draw: LFSR_W must be 8, 16, 24 or 32");
    end
    if (SEED_W == '0) begin : g_bad_seed
      $error("rng_draw: SEED must be non-zero after truncation to LFSR_W");
    end
    if (MIN_VAL >= MAX_VAL || MAX_VAL > 99 || MIN_VAL < 0) begin : g_bad_range
      $error("rng_draw: need 0 <= MIN_VAL < MAX_VAL <= 99");
    end
    if (MAX_TRY < 1 || DEBOUNCE_CYC < 1) begin : g_bad_counts
      $error("rng_draw: MAX_TRY and DEBOUNCE_CYC must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  logic clk;
  logic rst_n;
  assign clk   = CLOCK_50;
  assign rst_n = KEY[1];

  // ---------------------------------------------------------------- LFSR
  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED_W;
    end else if (lfsr == '0) begin
      lfsr <= SEED_W;
    end else if (lfsr[0]) begin
      lfsr <= (lfsr >> 1) ^ TAPS;
    end else begin
      lfsr <= lfsr >> 1;
    end
  end

  // ---------------------------------------------------------------- button
  logic             key_s1;
  logic             key_s2;
  logic             btn_db;
  logic [CNT_W-1:0] db_cnt;
  logic             db_hit;
  logic             press_pulse;

  // Counter only runs while the synchronised level disagrees with the accepted one.
  assign db_hit      = (key_s2 != btn_db) && (db_cnt == CNT_W'(DEBOUNCE_CYC - 1));
  assign press_pulse = db_hit && !key_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else begin
      key_s1 <= KEY[0];
      key_s2 <= key_s1;
      if (key_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_hit) begin
        btn_db <= key_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- draw FSM
  // Handshake: req is a level sampled only in IDLE; rand_valid is a one-cycle
  // pulse in DONE with rand_val already updated; there is no backpressure.
  state_t           state_q;
  state_t           state_d;
  logic [TRY_W-1:0] try_cnt;
  logic [TRY_W-1:0] try_d;
  logic             req;
  logic             load_val;
  logic [7:0]       samp;
  logic [7:0]       acc_val;
  logic             in_range;
  logic             last_try;

  assign req      = press_pulse | draw_req;
  assign samp     = 8'(lfsr[K-1:0]);
  assign in_range = samp < 8'(RANGE);
  assign last_try = try_cnt == TRY_W'(MAX_TRY - 1);
  // Fallback is safe: 2^K < 2*RANGE, so samp - RANGE lands inside the range.
  assign acc_val  = in_range ? samp : samp - 8'(RANGE);

  always_comb begin
    state_d  = state_q;
    try_d    = try_cnt;
    load_val = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SAMPLE;
          try_d   = '0;
        end
      end
      SAMPLE: begin
        if (in_range || last_try) begin
          state_d  = DONE;
          load_val = 1'b1;
        end else begin
          try_d = try_cnt + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      try_cnt    <= '0;
      rand_val   <= '0;
      draw_count <= '0;
    end else begin
      state_q <= state_d;
      try_cnt <= try_d;
      if (load_val) begin
        rand_val   <= VAL_W'(acc_val + 8'(MIN_VAL));
        draw_count <= draw_count + 8'd1;
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign rand_valid = (state_q == DONE);

  // ---------------------------------------------------------------- display
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [6:0] val7;
  logic [3:0] tens;
  logic [3:0] ones;

  assign val7 = 7'(rand_val);
  assign tens = 4'(val7 / 7'd10);
  assign ones = 4'(val7 % 7'd10);
  assign HEX0 = seg7(ones);
  assign HEX1 = (tens == 4'd0) ? 7'h7F : seg7(tens);

endmodule

// File: tb/tb_rng_draw.sv
// Directed bench for rng_draw: reset, single draw, debounced button, busy drop,
// back-to-back draws with wrap, and reset in the middle of a draw.
module tb_rng_draw;

  localparam int MIN_VAL = 1;
  localparam int MAX_VAL = 13;
  localparam int MAX_TRY = 8;
  localparam int DEB     = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic [1:0] key;
  logic       draw_req;
  logic [3:0] rand_val;
  logic       rand_valid;
  logic       busy;
  logic [7:0] draw_count;
  logic [6:0] hex0;
  logic [6:0] hex1;

  int vectors = 0;
  int errors  = 0;
  int exp_count = 0;
  int valid_total = 0;
  int hist[16];
  int wraps = 0;
  int prev_count = 0;
  logic [15:0] m_lfsr;

  rng_draw #(
    .LFSR_W(16), .SEED(32'h0000_ACE1), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL),
    .DEBOUNCE_CYC(DEB), .MAX_TRY(MAX_TRY)
  ) dut (
    .CLOCK_50(clk), .KEY(key), .draw_req(draw_req), .rand_val(rand_val),
    .rand_valid(rand_valid), .busy(busy), .draw_count(draw_count),
    .HEX0(hex0), .HEX1(hex1)
  );

  // ------------------------------------------------ clock / reset / model
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] n;
    if (l == 16'h0) return SEED;
    n = l >> 1;
    if (l[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  always @(posedge clk or negedge key[1]) begin
    if (!key[1]) m_lfsr <= SEED;
    else         m_lfsr <= lfsr_step(m_lfsr);
  end

  always @(negedge clk) if (rand_valid === 1'b1) valid_total++;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected value and latency for a draw whose first sample sees LFSR state l0.
  function automatic void predict(input logic [15:0] l0, output logic [3:0] val,
                                  output int lat);
    logic [15:0] l;
    int s;
    l = l0;
    val = 4'd0;
    lat = 0;
    for (int t = 0; t < MAX_TRY; t++) begin
      s = int'(l[3:0]);
      if (s < 13) begin
        val = 4'(s + MIN_VAL); lat = t + 2; return;
      end
      if (t == MAX_TRY - 1) begin
        val = 4'(s - 13 + MIN_VAL); lat = t + 2; return;
      end
      l = lfsr_step(l);
    end
  endfunction

  // ------------------------------------------------ driver tasks
  // Called at the first negedge where the DUT is in its first SAMPLE cycle.
  task automatic finish_draw(input string tag);
    logic [3:0] ev;
    int elat;
    int nval;
    int vlat;
    predict(m_lfsr, ev, elat);
    nval = 0;
    for (int c = 1; c <= MAX_TRY + 3; c++) begin
      @(negedge clk);
      if (rand_valid === 1'b1) begin
        nval++;
        draw_req = 1'b0;
        if (nval == 1) begin
          vlat = c + 1;
          exp_count = (exp_count + 1) % 256;
          hist[rand_val]++;
          if (exp_count == 0 && prev_count == 255 && draw_count === 8'd0) wraps++;
          prev_count = int'(draw_count);
          vectors++;
          if (rand_val !== ev) begin
            errors++; $display("FAIL %s value: got %0d want %0d", tag, rand_val, ev);
          end
          vectors++;
          if (rand_val < 4'(MIN_VAL) || rand_val > 4'(MAX_VAL)) begin
            errors++; $display("FAIL %s range: got %0d want 1..13", tag, rand_val);
          end
          vectors++;
          if (vlat != elat || vlat < 2 || vlat > MAX_TRY + 2) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", tag, vlat, elat);
          end
          vectors++;
          if (draw_count !== 8'(exp_count)) begin
            errors++; $display("FAIL %s draw_count: got %0d want %0d", tag, draw_count, exp_count);
          end
          vectors++;
          if (hex0 !== seg(ev % 10) || hex1 !== ((ev / 10 == 0) ? 7'h7F : seg(ev / 10))) begin
            errors++; $display("FAIL %s hex: got %h/%h for value %0d", tag, hex1, hex0, ev);
          end
          vectors++;
          if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_in_done: got %b want 1", tag, busy);
          end
        end
      end
    end
    vectors++;
    if (nval != 1) begin
      errors++; $display("FAIL %s valid_pulses: got %0d want 1", tag, nval);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_after: got %b want 0", tag, busy);
    end
  endtask

  task automatic strobe_draw(input string tag, input bit hold);
    @(negedge clk);
    draw_req = 1'b1;
    @(negedge clk);
    if (!hold) draw_req = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_rise: got %b want 1", tag, busy);
    end
    finish_draw(tag);
    draw_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (rand_val !== 4'd0 || rand_valid !== 1'b0 || busy !== 1'b0 || draw_count !== 8'd0) begin
      errors++;
      $display("FAIL %s outs: val=%0d valid=%b busy=%b cnt=%0d want 0/0/0/0",
               tag, rand_val, rand_valid, busy, draw_count);
    end
    vectors++;
    if (hex0 !== 7'b1000000 || hex1 !== 7'h7F) begin
      errors++; $display("FAIL %s hex: got %h/%h want 7f/40", tag, hex1, hex0);
    end
    vectors++;
    if (dut.lfsr !== SEED) begin
      errors++; $display("FAIL %s lfsr: got %h want %h", tag, dut.lfsr, SEED);
    end
  endtask

  // ------------------------------------------------ scenarios
  task automatic test_reset();
    logic [15:0] gold[3];
    gold[0] = 16'hE270; gold[1] = 16'h7138; gold[2] = 16'h389C;
    key = 2'b11;
    draw_req = 1'b0;
    #3 key = 2'b01;
    #20;
    check_reset_outputs("reset");
    @(negedge clk);
    key = 2'b11;
    exp_count = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (dut.lfsr !== gold[i]) begin
        errors++; $display("FAIL lfsr_step%0d: got %h want %h", i, dut.lfsr, gold[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (dut.lfsr !== m_lfsr) begin
        errors++; $display("FAIL lfsr_model%0d: got %h want %h", i, dut.lfsr, m_lfsr);
      end
    end
  endtask

  task automatic test_single_draw();
    strobe_draw("single", 1'b0);
  endtask

  task automatic test_bounce();
    int v0;
    int got;
    bit busy_seen;
    v0 = valid_total;
    busy_seen = 0;
    for (int r = 0; r < 3; r++) begin
      key[0] = 1'b0;
      repeat (5) begin @(negedge clk); if (busy === 1'b1) busy_seen = 1; end
      key[0] = 1'b1;
      repeat (5) begin @(negedge clk); if (busy === 1'b1) busy_seen = 1; end
    end
    repeat (20) begin @(negedge clk); if (busy === 1'b1) busy_seen = 1; end
    vectors++;
    if (busy_seen || valid_total != v0) begin
      errors++; $display("FAIL bounce_glitch: draws=%0d busy_seen=%0d want 0/0", valid_total - v0, busy_seen);
    end
    key[0] = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      @(negedge clk);
      if (busy === 1'b1) got = 1;
    end
    vectors++;
    if (got == 0) begin
      errors++; $display("FAIL bounce_press: got no draw want one within 40 cycles");
    end else begin
      finish_draw("bounce");
    end
    repeat (30) @(negedge clk);
    key[0] = 1'b1;
    repeat (40) @(negedge clk);
    vectors++;
    if (valid_total != v0 + 1) begin
      errors++; $display("FAIL bounce_total: got %0d draws want 1", valid_total - v0);
    end
  endtask

  task automatic test_busy_drop();
    int v0;
    int got;
    strobe_draw("held", 1'b1);
    v0 = valid_total;
    repeat (15) @(negedge clk);
    vectors++;
    if (valid_total != v0 || busy !== 1'b0) begin
      errors++; $display("FAIL held_extra: got %0d extra draws busy=%b want 0/0", valid_total - v0, busy);
    end
    key[0] = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      @(negedge clk);
      if (dut.press_pulse === 1'b1) got = 1;
    end
    vectors++;
    if (got == 0) begin
      errors++; $display("FAIL coincide_press: got no press want one within 40 cycles");
    end else begin
      draw_req = 1'b1;
      @(negedge clk);
      draw_req = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL coincide busy_rise: got %b want 1", busy);
      end
      v0 = valid_total;
      finish_draw("coincide");
      repeat (20) @(negedge clk);
      vectors++;
      if (valid_total != v0 + 1) begin
        errors++; $display("FAIL coincide_total: got %0d draws want 1", valid_total - v0);
      end
    end
    key[0] = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) hist[i] = 0;
    wraps = 0;
    for (int n = 0; n < 2000; n++) strobe_draw("b2b", 1'b0);
    for (int v = MIN_VAL; v <= MAX_VAL; v++) begin
      vectors++;
      if (hist[v] == 0) begin
        errors++; $display("FAIL b2b_cover: value %0d got 0 hits want >=1", v);
      end
    end
    vectors++;
    if (wraps < 1) begin
      errors++; $display("FAIL b2b_wrap: got %0d wraps want >=1", wraps);
    end
  endtask

  task automatic test_reset_mid_draw();
    int v0;
    @(negedge clk);
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midrst busy_rise: got %b want 1", busy);
    end
    #2 key[1] = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    key[1] = 1'b1;
    exp_count = 0;
    v0 = valid_total;
    repeat (20) @(negedge clk);
    vectors++;
    if (valid_total != v0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_quiet: got %0d draws busy=%b want 0/0", valid_total - v0, busy);
    end
    strobe_draw("after_rst", 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_draw();
    test_bounce();
    test_busy_drop();
    test_back_to_back();
    test_reset_mid_draw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
